// File: rtl/ahb_wrr_output_arbiter.sv
// ahb_wrr_output_arbiter
//   Weighted round-robin arbiter for one bus-matrix output stage. Shares a
//   single slave port between NUM_PORTS input stages, giving each port a
//   programmable number of transfers per turn. Ownership is held across
//   fixed-length bursts, short INCR bursts and locked sequences. A one-stage
//   pipeline tracks which port owns the data phase.
//
// Ports:
//   HCLK, HRESETn  clock and asynchronous active-low reset
//   req            per-port request, bit i = port i
//   weight_cfg     per-port transfer quantum, QUANTUM_W bits per port
//   HREADYM        slave-side HREADY; qualifies every register update
//   HSELM          output stage currently selecting the slave
//   HTRANSM        transfer type at the output stage
//   HBURSTM        burst type at the output stage
//   HMASTLOCKM     locked transfer at the output stage
//   addr_in_port   port owning the address phase
//   no_port        no port owns the address phase
//   data_in_port   port owning the data phase
//   data_valid     data phase holds a real NONSEQ/SEQ transfer
module ahb_wrr_output_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int PORT_W    = 2,
  parameter int QUANTUM_W = 4
) (
  input  logic                           HCLK,
  input  logic                           HRESETn,
  input  logic [NUM_PORTS-1:0]           req,
  input  logic [NUM_PORTS*QUANTUM_W-1:0] weight_cfg,
  input  logic                           HREADYM,
  input  logic                           HSELM,
  input  logic [1:0]                     HTRANSM,
  input  logic [2:0]                     HBURSTM,
  input  logic                           HMASTLOCKM,
  output logic [PORT_W-1:0]              addr_in_port,
  output logic                           no_port,
  output logic [PORT_W-1:0]              data_in_port,
  output logic                           data_valid
);

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_BUSY   = 2'b01;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;

  logic [3:0]           burst_cnt, burst_nxt;
  logic [QUANTUM_W-1:0] credit, credit_after, credit_nxt;
  logic [PORT_W-1:0]    addr_nxt;
  logic                 no_port_nxt;
  logic                 hold;
  logic                 xfer;
  logic                 low_found, rot_found;
  logic [PORT_W-1:0]    low_idx, rot_idx;

  // Quantum loaded on a grant; a zero weight still allows one transfer.
  function automatic logic [QUANTUM_W-1:0] quantum_of(input logic [PORT_W-1:0] p);
    logic [QUANTUM_W-1:0] w;
    w = weight_cfg[int'(p)*QUANTUM_W +: QUANTUM_W];
    return (w == '0) ? QUANTUM_W'(1) : w;
  endfunction

  // Remaining beats after this transfer. INCR is treated as a 4-beat burst so
  // the owner keeps the slave for a short undefined-length sequence.
  always_comb begin
    burst_nxt = 4'd0;
    if (HSELM) begin
      case (HTRANSM)
        TR_NONSEQ: begin
          case (HBURSTM)
            3'b001, 3'b010, 3'b011: burst_nxt = 4'd3;
            3'b100, 3'b101:         burst_nxt = 4'd7;
            3'b110, 3'b111:         burst_nxt = 4'd15;
            default:                burst_nxt = 4'd0;
          endcase
        end
        TR_SEQ:  burst_nxt = (burst_cnt == 4'd0) ? 4'd0 : burst_cnt - 4'd1;
        TR_BUSY: burst_nxt = burst_cnt;
        default: burst_nxt = 4'd0;
      endcase
    end
  end

  assign hold = HMASTLOCKM | (burst_nxt != 4'd0);
  assign xfer = HSELM & HTRANSM[1] & ~no_port;
  assign credit_after = (xfer && credit != '0) ? credit - QUANTUM_W'(1) : credit;

  // Two requester searches: lowest index (used from the idle state) and the
  // round-robin search starting just after the owner, ending on the owner.
  always_comb begin
    low_found = 1'b0;
    low_idx   = '0;
    rot_found = 1'b0;
    rot_idx   = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (req[i] && !low_found) begin
        low_found = 1'b1;
        low_idx   = PORT_W'(i);
      end
    end
    for (int k = 1; k <= NUM_PORTS; k++) begin
      int idx;
      idx = (int'(addr_in_port) + k) % NUM_PORTS;
      if (req[idx] && !rot_found) begin
        rot_found = 1'b1;
        rot_idx   = PORT_W'(idx);
      end
    end
  end

  // Ownership decision. While hold is set only the credit moves; otherwise
  // the owner keeps the slave while it has credit left and still requests.
  always_comb begin
    addr_nxt    = addr_in_port;
    no_port_nxt = no_port;
    credit_nxt  = credit_after;
    if (!hold) begin
      if (no_port) begin
        if (low_found) begin
          addr_nxt    = low_idx;
          no_port_nxt = 1'b0;
          credit_nxt  = quantum_of(low_idx);
        end
      end else if (req[addr_in_port] && credit_after != '0) begin
        addr_nxt = addr_in_port;
      end else if (rot_found) begin
        addr_nxt   = rot_idx;
        credit_nxt = quantum_of(rot_idx);
      end else if (!HSELM) begin
        no_port_nxt = 1'b1;
      end
    end
  end

  // State registers; every update is qualified by the slave's HREADY.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      addr_in_port <= '0;
      no_port      <= 1'b1;
      data_in_port <= '0;
      data_valid   <= 1'b0;
      burst_cnt    <= 4'd0;
      credit       <= '0;
    end else if (HREADYM) begin
      addr_in_port <= addr_nxt;
      no_port      <= no_port_nxt;
      data_in_port <= addr_in_port;
      data_valid   <= ~no_port & HSELM & HTRANSM[1];
      burst_cnt    <= burst_nxt;
      credit       <= credit_nxt;
    end
  end

endmodule

// File: tb/tb_ahb_wrr_output_arbiter.sv
// tb_ahb_wrr_output_arbiter
//   Table-driven bench for the weighted round-robin output arbiter. Each
//   record holds one cycle of inputs and the outputs expected after the
//   following HCLK edge; expected values go into a scoreboard queue when the
//   stimulus is driven and are popped when the outputs are sampled.
module tb_ahb_wrr_output_arbiter;

  localparam logic [1:0] IDLE = 2'b00, BUSY = 2'b01, NSEQ = 2'b10, SEQ = 2'b11;
  localparam logic [2:0] SINGLE = 3'b000, INCR4 = 3'b011, INCR8 = 3'b101, INCR16 = 3'b111;
  localparam logic [15:0] W_A = 16'h2222, W_C = 16'h2212, W_E = 16'h1212, W_F = 16'h1210;

  logic        HCLK, HRESETn;
  logic [3:0]  req;
  logic [15:0] weight_cfg;
  logic        HREADYM, HSELM, HMASTLOCKM;
  logic [1:0]  HTRANSM;
  logic [2:0]  HBURSTM;
  logic [1:0]  addr_in_port, data_in_port;
  logic        no_port, data_valid;

  typedef struct {
    logic        rdy;
    logic        sel;
    logic [1:0]  trans;
    logic [2:0]  burst;
    logic        lock;
    logic [3:0]  req;
    logic [15:0] wcfg;
    logic [1:0]  e_addr;
    logic        e_nop;
    logic [1:0]  e_data;
    logic        e_dv;
    string       tag;
  } vec_t;

  typedef struct {
    logic [1:0] addr;
    logic       nop;
    logic [1:0] data;
    logic       dv;
    string      tag;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   vec_count  = 0;
  int   miss_count = 0;

  ahb_wrr_output_arbiter #(.NUM_PORTS(4), .PORT_W(2), .QUANTUM_W(4)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .req(req), .weight_cfg(weight_cfg),
    .HREADYM(HREADYM), .HSELM(HSELM), .HTRANSM(HTRANSM), .HBURSTM(HBURSTM),
    .HMASTLOCKM(HMASTLOCKM), .addr_in_port(addr_in_port), .no_port(no_port),
    .data_in_port(data_in_port), .data_valid(data_valid)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  function automatic vec_t mk(input logic rdy, input logic sel, input logic [1:0] trans,
                              input logic [2:0] burst, input logic lock, input logic [3:0] rq,
                              input logic [15:0] w, input logic [1:0] ea, input logic en,
                              input logic [1:0] ed, input logic edv, input string tag);
    vec_t v;
    v.rdy = rdy; v.sel = sel; v.trans = trans; v.burst = burst; v.lock = lock;
    v.req = rq; v.wcfg = w; v.e_addr = ea; v.e_nop = en; v.e_data = ed; v.e_dv = edv;
    v.tag = tag;
    return v;
  endfunction

  // Drive one cycle of inputs and queue the outputs expected after the edge.
  task automatic applyStimulus(input vec_t v);
    exp_t e;
    HREADYM = v.rdy; HSELM = v.sel; HTRANSM = v.trans; HBURSTM = v.burst;
    HMASTLOCKM = v.lock; req = v.req; weight_cfg = v.wcfg;
    e.addr = v.e_addr; e.nop = v.e_nop; e.data = v.e_data; e.dv = v.e_dv; e.tag = v.tag;
    sb.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t e;
    vec_count++;
    if (sb.size() == 0) begin
      miss_count++;
      $display("[TB] FAIL scoreboard_empty: no expected entry queued");
      return;
    end
    e = sb.pop_front();
    if (addr_in_port !== e.addr || no_port !== e.nop || data_in_port !== e.data ||
        data_valid !== e.dv) begin
      miss_count++;
      $display("[TB] FAIL %s: got addr=%0d nop=%0b data=%0d dv=%0b, want addr=%0d nop=%0b data=%0d dv=%0b",
               e.tag, addr_in_port, no_port, data_in_port, data_valid, e.addr, e.nop, e.data, e.dv);
    end
  endtask

  task automatic check_reset(input string tag);
    vec_count++;
    if (addr_in_port !== 2'd0 || no_port !== 1'b1 || data_in_port !== 2'd0 || data_valid !== 1'b0) begin
      miss_count++;
      $display("[TB] FAIL %s: got addr=%0d nop=%0b data=%0d dv=%0b, want addr=0 nop=1 data=0 dv=0",
               tag, addr_in_port, no_port, data_in_port, data_valid);
    end
  endtask

  initial begin
    HRESETn = 1'b0; req = '0; weight_cfg = W_A; HREADYM = 1'b1; HSELM = 1'b0;
    HTRANSM = IDLE; HBURSTM = SINGLE; HMASTLOCKM = 1'b0;

    // Single grant, then release to the idle state.
    vecs.push_back(mk(1,0,IDLE,SINGLE,0,4'b0100,W_A, 2,0,0,0,"grant_p2"));
    vecs.push_back(mk(1,0,IDLE,SINGLE,0,4'b0000,W_A, 2,1,2,0,"release_nop"));
    // Weights 2, all requesting: two transfers per port, round robin.
    vecs.push_back(mk(1,0,IDLE,SINGLE,0,4'b1111,W_A, 0,0,2,0,"grant_lowest"));
    vecs.push_back(mk(1,1,NSEQ,SINGLE,0,4'b1111,W_A, 0,0,0,1,"wrr_keep0"));
    vecs.push_back(mk(1,1,NSEQ,SINGLE,0,4'b1111,W_A, 1,0,0,1,"wrr_rot1"));
    vecs.push_back(mk(1,1,NSEQ,SINGLE,0,4'b1111,W_A, 1,0,1,1,"wrr_keep1"));
    vecs.push_back(mk(1,1,NSEQ,SINGLE,0,4'b1111,W_A, 2,0,1,1,"wrr_rot2"));
    vecs.push_back(mk(1,1,NSEQ,SINGLE,0,4'b1111,W_A, 2,0,2,1,"wrr_keep2"));
    vecs.push_back(mk(1,1,NSEQ,SINGLE,0,4'b1111,W_A, 3,0,2,1,"wrr_rot3"));
    vecs.push_back(mk(1,1,NSEQ,SINGLE,0,4'b1111,W_A, 3,0,3,1,"wrr_keep3"));
    vecs.push_back(mk(1,1,NSEQ,SINGLE,0,4'b1111,W_A, 0,0,3,1,"wrr_wrap0"));
    // Port 1 gets weight 1, then runs an INCR8 that holds past its credit.
    vecs.push_back(mk(1,1,NSEQ,SINGLE,0,4'b1111,W_C, 0,0,0,1,"pre8_keep0"));
    vecs.push_back(mk(1,1,NSEQ,SINGLE,0,4'b1111,W_C, 1,0,0,1,"pre8_rot1"));
    vecs.push_back(mk(1,1,NSEQ,INCR8, 0,4'b1111,W_C, 1,0,1,1,"incr8_beat1"));
    for (int i = 0; i < 6; i++)
      vecs.push_back(mk(1,1,SEQ,INCR8,0,4'b1111,W_C, 1,0,1,1,"incr8_hold"));
    vecs.push_back(mk(1,1,SEQ,INCR8,0,4'b1111,W_C, 2,0,1,1,"incr8_last_rot"));
    // INCR4 with three wait states in the middle.
    vecs.push_back(mk(1,1,NSEQ,INCR4,0,4'b1111,W_C, 2,0,2,1,"incr4_beat1"));
    vecs.push_back(mk(1,1,SEQ, INCR4,0,4'b1111,W_C, 2,0,2,1,"incr4_beat2"));
    vecs.push_back(mk(0,1,SEQ, INCR4,0,4'b1111,W_C, 2,0,2,1,"wait_frozen1"));
    vecs.push_back(mk(0,1,SEQ, INCR4,0,4'b0000,W_C, 2,0,2,1,"wait_frozen2"));
    vecs.push_back(mk(0,1,SEQ, INCR4,0,4'b1111,W_C, 2,0,2,1,"wait_frozen3"));
    vecs.push_back(mk(1,1,SEQ, INCR4,0,4'b1111,W_C, 2,0,2,1,"incr4_beat3"));
    vecs.push_back(mk(1,1,SEQ, INCR4,0,4'b1111,W_E, 3,0,2,1,"incr4_last_rot"));
    // Port 3 (weight 1) locked for six transfers, then one unlocked.
    for (int i = 0; i < 6; i++)
      vecs.push_back(mk(1,1,NSEQ,SINGLE,1,4'b1111,W_E, 3,0,3,1,"locked_hold"));
    vecs.push_back(mk(1,1,NSEQ,SINGLE,0,4'b1111,W_E, 0,0,3,1,"unlock_rot0"));
    // Port 0 alone with weight 0: regranted every transfer.
    vecs.push_back(mk(1,1,NSEQ,SINGLE,0,4'b0001,W_F, 0,0,0,1,"solo_keep"));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(1,1,NSEQ,SINGLE,0,4'b0001,W_F, 0,0,0,1,"solo_regrant"));
    vecs.push_back(mk(1,0,IDLE,SINGLE,0,4'b0000,W_F, 0,1,0,0,"drop_nop"));
    vecs.push_back(mk(1,0,IDLE,SINGLE,0,4'b0000,W_F, 0,1,0,0,"idle_stays_nop"));
    // Owner parked on IDLE with HSELM=1 and nobody requesting.
    vecs.push_back(mk(1,0,IDLE,SINGLE,0,4'b0010,W_F, 1,0,0,0,"grant_p1"));
    vecs.push_back(mk(1,1,IDLE,SINGLE,0,4'b0000,W_F, 1,0,1,0,"parked_keep"));

    repeat (2) @(posedge HCLK);
    @(negedge HCLK);
    HRESETn = 1'b1;
    #1 check_reset("reset_state");

    foreach (vecs[i]) begin
      @(negedge HCLK);
      applyStimulus(vecs[i]);
      @(posedge HCLK);
      #1 checkOutput();
    end

    // Reset in the middle of an INCR16 must leave no residual hold: a SEQ
    // right after reset must not block the grant from the idle state.
    @(negedge HCLK);
    applyStimulus(mk(1,1,NSEQ,INCR16,0,4'b0010,W_F, 1,0,1,1,"incr16_start"));
    @(posedge HCLK);
    #1 checkOutput();
    @(negedge HCLK);
    HRESETn = 1'b0;
    #1 check_reset("async_reset_midburst");
    #1 HRESETn = 1'b1;
    applyStimulus(mk(1,1,SEQ,INCR16,0,4'b0010,W_F, 1,0,0,0,"post_reset_no_hold"));
    @(posedge HCLK);
    #1 checkOutput();

    if (sb.size() != 0) begin
      miss_count++;
      $display("[TB] FAIL scoreboard_leftover: %0d entries, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
